// File: rtl/rf_result_pipe_if.sv
// Purpose: EX-stage result bus into the result pipe, grouping the valid/allowin
//   handshake with the EX payload (write-back target, ALU result, load attributes).
// Modports:
//   master - EX datapath: drives ex_valid and the payload, observes ex_allowin
//   slave  - rf_result_pipe: observes ex_valid and the payload, drives ex_allowin
interface rf_result_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ex_valid;
  logic              ex_allowin;
  logic              ex_rf_we;
  logic [ADDR_W-1:0] ex_rf_waddr;
  logic [DATA_W-1:0] ex_rf_wdata;
  logic              ex_mem_re;
  logic [1:0]        ex_ld_size;
  logic              ex_ld_unsigned;
  logic [1:0]        ex_addr_lo;

  modport master (
    output ex_valid, ex_rf_we, ex_rf_waddr, ex_rf_wdata,
    output ex_mem_re, ex_ld_size, ex_ld_unsigned, ex_addr_lo,
    input  ex_allowin
  );

  modport slave (
    input  ex_valid, ex_rf_we, ex_rf_waddr, ex_rf_wdata,
    input  ex_mem_re, ex_ld_size, ex_ld_unsigned, ex_addr_lo,
    output ex_allowin
  );
endinterface

// File: rtl/rf_result_pipe.sv
// Purpose: EX->MEM and MEM->WB result registers of the integer pipeline. Sources the
//   EX/MEM/WB forwarding buses for the ID-stage bypass, merges data-SRAM load returns
//   (discarding responses that belong to flushed loads), and drives the regfile write port.
// Configuration: define LOAD_EXT_EN to enable byte/half extraction with sign/zero
//   extension; without it every load returns the full mem_rdata word.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ex_if (slave)     EX handshake + payload (valid/allowin, we, waddr, wdata, load attrs)
//   mem_rdata/_ok     data-SRAM read response
//   flush             kills EX and MEM contents
//   fwd_ex_*          EX forward bus (combinational)
//   fwd_mem_*         MEM forward bus
//   fwd_wb_*          WB forward bus (same as regfile write port)
//   rf_we/waddr/wdata regfile write port
module rf_result_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  rf_result_pipe_if.slave   ex_if,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_ok,
  input  logic              flush,
  output logic              fwd_ex_rf_we,
  output logic [ADDR_W-1:0] fwd_ex_rf_waddr,
  output logic [DATA_W-1:0] fwd_ex_rf_wdata,
  output logic              fwd_ex_mem_re,
  output logic              fwd_mem_rf_we,
  output logic [ADDR_W-1:0] fwd_mem_rf_waddr,
  output logic [DATA_W-1:0] fwd_mem_rf_wdata,
  output logic              fwd_mem_mem_re,
  output logic              fwd_wb_rf_we,
  output logic [ADDR_W-1:0] fwd_wb_rf_waddr,
  output logic [DATA_W-1:0] fwd_wb_rf_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

`ifdef LOAD_EXT_EN
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] rdata,
    input logic [1:0]        size,
    input logic              uns,
    input logic [1:0]        lo
  );
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic               fill;
    b = 8'(rdata >> {lo, 3'b000});
    h = 16'(rdata >> {lo[1], 4'b0000});
    case (size)
      2'd0: begin
        fill = ~uns & b[7];
        load_extend = {{(DATA_W-8){fill}}, b};
      end
      2'd1: begin
        fill = ~uns & h[15];
        load_extend = {{(DATA_W-16){fill}}, h};
      end
      default: load_extend = rdata;
    endcase
  endfunction
`endif

  // EX stage: writes to r0 are dropped here so no bus ever advertises them.
  logic ex_we_eff;
  assign ex_we_eff = ex_if.ex_rf_we & (ex_if.ex_rf_waddr != '0);

  logic              vld_p1_q, vld_p1_d;
  logic              we_p1_q, we_p1_d;
  logic [ADDR_W-1:0] waddr_p1_q, waddr_p1_d;
  logic [DATA_W-1:0] alu_p1_q, alu_p1_d;
  logic              mre_p1_q, mre_p1_d;
`ifdef LOAD_EXT_EN
  logic [1:0]        size_p1_q, size_p1_d;
  logic              uns_p1_q, uns_p1_d;
  logic [1:0]        lo_p1_q, lo_p1_d;
`else
  logic              unused_ld_attrs;
  assign unused_ld_attrs = ^{ex_if.ex_ld_size, ex_if.ex_ld_unsigned, ex_if.ex_addr_lo};
`endif
  logic              drop_pend_q, drop_pend_d;

  logic              vld_p2_q, vld_p2_d;
  logic              we_p2_q, we_p2_d;
  logic [ADDR_W-1:0] waddr_p2_q, waddr_p2_d;
  logic [DATA_W-1:0] wdata_p2_q, wdata_p2_d;

  logic              ok_eff;
  logic              ready_go;
  logic              mem_allowin;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] mem_wdata;

  // A response arriving while drop_pend is set belongs to a flushed load.
  assign ok_eff      = mem_data_ok & ~drop_pend_q;
  assign ready_go    = ~mre_p1_q | ok_eff;
  assign mem_allowin = ~vld_p1_q | ready_go;
  assign ex_if.ex_allowin = mem_allowin;

`ifdef LOAD_EXT_EN
  assign ld_data = load_extend(mem_rdata, size_p1_q, uns_p1_q, lo_p1_q);
`else
  assign ld_data = mem_rdata;
`endif
  assign mem_wdata = mre_p1_q ? ld_data : alu_p1_q;

  always_comb begin
    vld_p1_d   = flush ? 1'b0 : (mem_allowin ? ex_if.ex_valid : vld_p1_q);
    we_p1_d    = we_p1_q;
    waddr_p1_d = waddr_p1_q;
    alu_p1_d   = alu_p1_q;
    mre_p1_d   = mre_p1_q;
`ifdef LOAD_EXT_EN
    size_p1_d  = size_p1_q;
    uns_p1_d   = uns_p1_q;
    lo_p1_d    = lo_p1_q;
`endif
    if (ex_if.ex_valid & mem_allowin) begin
      we_p1_d    = ex_we_eff;
      waddr_p1_d = ex_if.ex_rf_waddr;
      alu_p1_d   = ex_if.ex_rf_wdata;
      mre_p1_d   = ex_if.ex_mem_re;
`ifdef LOAD_EXT_EN
      size_p1_d  = ex_if.ex_ld_size;
      uns_p1_d   = ex_if.ex_ld_unsigned;
      lo_p1_d    = ex_if.ex_addr_lo;
`endif
    end

    // Flushing a load whose data has not arrived leaves one response in flight that
    // must be swallowed; a response in the flush cycle itself is simply discarded.
    drop_pend_d = drop_pend_q;
    if (flush & vld_p1_q & mre_p1_q & ~ok_eff)
      drop_pend_d = 1'b1;
    else if (drop_pend_q & mem_data_ok)
      drop_pend_d = 1'b0;

    vld_p2_d   = vld_p1_q & ready_go & ~flush;
    we_p2_d    = we_p2_q;
    waddr_p2_d = waddr_p2_q;
    wdata_p2_d = wdata_p2_q;
    if (vld_p1_q & ready_go) begin
      we_p2_d    = we_p1_q;
      waddr_p2_d = waddr_p1_q;
      wdata_p2_d = mem_wdata;
    end
  end

  // EX -> MEM and MEM -> WB boundaries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q    <= 1'b0;
      we_p1_q     <= 1'b0;
      waddr_p1_q  <= '0;
      alu_p1_q    <= '0;
      mre_p1_q    <= 1'b0;
`ifdef LOAD_EXT_EN
      size_p1_q   <= '0;
      uns_p1_q    <= 1'b0;
      lo_p1_q     <= '0;
`endif
      drop_pend_q <= 1'b0;
      vld_p2_q    <= 1'b0;
      we_p2_q     <= 1'b0;
      waddr_p2_q  <= '0;
      wdata_p2_q  <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      we_p1_q     <= we_p1_d;
      waddr_p1_q  <= waddr_p1_d;
      alu_p1_q    <= alu_p1_d;
      mre_p1_q    <= mre_p1_d;
`ifdef LOAD_EXT_EN
      size_p1_q   <= size_p1_d;
      uns_p1_q    <= uns_p1_d;
      lo_p1_q     <= lo_p1_d;
`endif
      drop_pend_q <= drop_pend_d;
      vld_p2_q    <= vld_p2_d;
      we_p2_q     <= we_p2_d;
      waddr_p2_q  <= waddr_p2_d;
      wdata_p2_q  <= wdata_p2_d;
    end
  end

  assign fwd_ex_rf_we    = ex_if.ex_valid & ex_we_eff & ~flush;
  assign fwd_ex_rf_waddr = ex_if.ex_rf_waddr;
  assign fwd_ex_rf_wdata = ex_if.ex_rf_wdata;
  assign fwd_ex_mem_re   = ex_if.ex_valid & ex_if.ex_mem_re;

  // A pending load tells the consumer to stall; once data arrives it forwards directly.
  assign fwd_mem_rf_we    = vld_p1_q & we_p1_q;
  assign fwd_mem_rf_waddr = waddr_p1_q;
  assign fwd_mem_rf_wdata = mem_wdata;
  assign fwd_mem_mem_re   = vld_p1_q & mre_p1_q & ~ok_eff;

  assign rf_we    = vld_p2_q & we_p2_q;
  assign rf_waddr = waddr_p2_q;
  assign rf_wdata = wdata_p2_q;

  assign fwd_wb_rf_we    = rf_we;
  assign fwd_wb_rf_waddr = rf_waddr;
  assign fwd_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_result_pipe.sv
module tb_rf_result_pipe;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef LOAD_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_ok;
  logic              flush;
  logic              fwd_ex_rf_we, fwd_ex_mem_re;
  logic [ADDR_W-1:0] fwd_ex_rf_waddr;
  logic [DATA_W-1:0] fwd_ex_rf_wdata;
  logic              fwd_mem_rf_we, fwd_mem_mem_re;
  logic [ADDR_W-1:0] fwd_mem_rf_waddr;
  logic [DATA_W-1:0] fwd_mem_rf_wdata;
  logic              fwd_wb_rf_we;
  logic [ADDR_W-1:0] fwd_wb_rf_waddr;
  logic [DATA_W-1:0] fwd_wb_rf_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  rf_result_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) exif ();

  rf_result_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ex_if(exif.slave),
    .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok), .flush(flush),
    .fwd_ex_rf_we(fwd_ex_rf_we), .fwd_ex_rf_waddr(fwd_ex_rf_waddr),
    .fwd_ex_rf_wdata(fwd_ex_rf_wdata), .fwd_ex_mem_re(fwd_ex_mem_re),
    .fwd_mem_rf_we(fwd_mem_rf_we), .fwd_mem_rf_waddr(fwd_mem_rf_waddr),
    .fwd_mem_rf_wdata(fwd_mem_rf_wdata), .fwd_mem_mem_re(fwd_mem_mem_re),
    .fwd_wb_rf_we(fwd_wb_rf_we), .fwd_wb_rf_waddr(fwd_wb_rf_waddr),
    .fwd_wb_rf_wdata(fwd_wb_rf_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    int                cyc;
  } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int wa, input logic [DATA_W-1:0] wd, input int at);
    wr_t e;
    e.waddr = ADDR_W'(wa);
    e.wdata = wd;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  // Load result from the architectural rules: pick the addressed byte/half, then extend.
  function automatic logic [DATA_W-1:0] ld_model(input logic [DATA_W-1:0] d, input int size,
                                                 input bit uns, input int lo);
    longint v;
    if (!EXT_EN || size >= 2) return d;
    if (size == 0) begin
      v = (longint'(d) >> (8 * lo)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else begin
      v = (longint'(d) >> (16 * (lo / 2))) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[DATA_W-1:0];
  endfunction

  // Scoreboard monitor: every regfile write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b1 && rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.waddr || rf_wdata !== e.wdata || cyc != e.cyc ||
            fwd_wb_rf_we !== 1'b1 || fwd_wb_rf_waddr !== e.waddr || fwd_wb_rf_wdata !== e.wdata) begin
          errors++;
          $display("FAIL rf_write: got r%0d=%h at cycle %0d (wb bus r%0d=%h we=%b) expected r%0d=%h at cycle %0d",
                   rf_waddr, rf_wdata, cyc, fwd_wb_rf_waddr, fwd_wb_rf_wdata, fwd_wb_rf_we,
                   e.waddr, e.wdata, e.cyc);
        end
      end
    end
  end

  task automatic drive_ex(input bit v, input bit we, input int wa, input logic [DATA_W-1:0] wd,
                          input bit re, input int sz, input bit un, input int lo);
    exif.ex_valid       = v;
    exif.ex_rf_we       = we;
    exif.ex_rf_waddr    = ADDR_W'(wa);
    exif.ex_rf_wdata    = wd;
    exif.ex_mem_re      = re;
    exif.ex_ld_size     = 2'(sz);
    exif.ex_ld_unsigned = un;
    exif.ex_addr_lo     = 2'(lo);
  endtask

  task automatic idle_ex();
    drive_ex(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idle_ex();
      mem_data_ok = 1'b0;
      flush = 1'b0;
    end
  endtask

  // Single load with immediate response, checked by constant expectation.
  task automatic load_now(input string name, input int wa, input int sz, input bit un, input int lo,
                          input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    drive_ex(1, 1, wa, 32'h0BAD_0BAD, 1, sz, un, lo);
    @(negedge clk);
    idle_ex();
    mem_data_ok = 1'b1;
    mem_rdata = rd;
    #1;
    chk({name, "_fwd_mem_wdata"}, fwd_mem_rf_wdata, exp);
    push_wr(wa, exp, cyc + 1);
    @(negedge clk);
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold;
    bit pend;
    int pw;
    logic [DATA_W-1:0] pd;

    rst = 1'b0;
    flush = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    idle_ex();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_fwd_mem_we", fwd_mem_rf_we, 0);
    chk("rst_fwd_mem_re", fwd_mem_mem_re, 0);
    chk("rst_fwd_mem_wdata", fwd_mem_rf_wdata, 0);
    chk("rst_fwd_wb_we", fwd_wb_rf_we, 0);
    chk("rst_allowin", exif.ex_allowin, 1);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);

    // ALU r5 <= 0x1234
    @(negedge clk);
    drive_ex(1, 1, 5, 32'h1234, 0, 2, 0, 0);
    #1;
    chk("alu_fwd_ex_we", fwd_ex_rf_we, 1);
    chk("alu_fwd_ex_waddr", fwd_ex_rf_waddr, 5);
    chk("alu_fwd_ex_wdata", fwd_ex_rf_wdata, 32'h1234);
    push_wr(5, 32'h1234, cyc + 2);
    @(negedge clk);
    idle_ex();
    #1;
    chk("alu_fwd_mem_we", fwd_mem_rf_we, 1);
    chk("alu_fwd_mem_waddr", fwd_mem_rf_waddr, 5);
    chk("alu_fwd_mem_wdata", fwd_mem_rf_wdata, 32'h1234);
    chk("alu_fwd_mem_re", fwd_mem_mem_re, 0);
    idle_cycles(2);

    // Load extraction
    load_now("ldb_s", 3, 0, 0, 3, 32'h80123456, EXT_EN ? 32'hFFFFFF80 : 32'h80123456);
    load_now("ldb_u", 3, 0, 1, 3, 32'h80123456, EXT_EN ? 32'h00000080 : 32'h80123456);
    load_now("ldh_s", 4, 1, 0, 2, 32'h80017777, EXT_EN ? 32'hFFFF8001 : 32'h80017777);
    load_now("ldh_u", 4, 1, 1, 0, 32'h1234F00D, EXT_EN ? 32'h0000F00D : 32'h1234F00D);
    load_now("ldw", 6, 2, 0, 0, 32'hCAFEBABE, 32'hCAFEBABE);
    idle_cycles(2);

    // Load with data_ok three cycles late; ALU r8 waits behind it in EX
    @(negedge clk);
    drive_ex(1, 1, 7, '0, 1, 2, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive_ex(1, 1, 8, 32'h55, 0, 2, 0, 0);
      #1;
      chk("late_fwd_mem_re", fwd_mem_mem_re, 1);
      chk("late_allowin", exif.ex_allowin, 0);
    end
    @(negedge clk);
    mem_data_ok = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    chk("late_ok_fwd_mem_re", fwd_mem_mem_re, 0);
    chk("late_ok_allowin", exif.ex_allowin, 1);
    chk("late_ok_wdata", fwd_mem_rf_wdata, 32'hCAFEF00D);
    push_wr(7, 32'hCAFEF00D, cyc + 1);
    push_wr(8, 32'h55, cyc + 2);
    idle_cycles(4);

    // Flush with a load pending, new load enters, two responses: only the second counts
    @(negedge clk);
    drive_ex(1, 1, 9, '0, 1, 2, 0, 0);
    @(negedge clk);
    idle_ex();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive_ex(1, 1, 10, '0, 1, 2, 0, 0);
    #1;
    chk("flush_new_allowin", exif.ex_allowin, 1);
    @(negedge clk);
    idle_ex();
    mem_data_ok = 1'b1;
    mem_rdata = 32'h0000AAAA;
    #1;
    chk("flush_drop_fwd_mem_re", fwd_mem_mem_re, 1);
    chk("flush_drop_allowin", exif.ex_allowin, 0);
    @(negedge clk);
    mem_rdata = 32'h0000BBBB;
    #1;
    chk("flush_keep_fwd_mem_re", fwd_mem_mem_re, 0);
    chk("flush_keep_wdata", fwd_mem_rf_wdata, 32'h0000BBBB);
    push_wr(10, 32'h0000BBBB, cyc + 1);
    idle_cycles(3);

    // Flush coincident with data_ok: nothing left to drop; EX instruction killed too
    @(negedge clk);
    drive_ex(1, 1, 11, '0, 1, 2, 0, 0);
    @(negedge clk);
    drive_ex(1, 1, 13, 32'h77, 0, 2, 0, 0);
    flush = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h00001111;
    #1;
    chk("flush_ok_fwd_ex_we", fwd_ex_rf_we, 0);
    @(negedge clk);
    flush = 1'b0;
    mem_data_ok = 1'b0;
    drive_ex(1, 1, 12, '0, 1, 2, 0, 0);
    @(negedge clk);
    idle_ex();
    mem_data_ok = 1'b1;
    mem_rdata = 32'h00002222;
    #1;
    chk("flush_ok_next_fwd_mem_re", fwd_mem_mem_re, 0);
    push_wr(12, 32'h00002222, cyc + 1);
    idle_cycles(3);

    // Writes to r0 are invisible everywhere
    @(negedge clk);
    drive_ex(1, 1, 0, 32'h999, 0, 2, 0, 0);
    #1;
    chk("r0_fwd_ex_we", fwd_ex_rf_we, 0);
    @(negedge clk);
    idle_ex();
    #1;
    chk("r0_fwd_mem_we", fwd_mem_rf_we, 0);
    @(negedge clk);
    #1;
    chk("r0_rf_we", rf_we, 0);
    chk("r0_fwd_wb_we", fwd_wb_rf_we, 0);
    idle_cycles(2);

    // Reset asserted while a load waits in MEM
    @(negedge clk);
    drive_ex(1, 1, 15, '0, 1, 2, 0, 0);
    @(negedge clk);
    idle_ex();
    #1;
    chk("rstmid_pre_fwd_mem_re", fwd_mem_mem_re, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_fwd_mem_re", fwd_mem_mem_re, 0);
    chk("rstmid_fwd_mem_we", fwd_mem_rf_we, 0);
    chk("rstmid_rf_we", rf_we, 0);
    chk("rstmid_allowin", exif.ex_allowin, 1);
    @(negedge clk);
    rst = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h0000DEAD;
    idle_cycles(4);

    // Randomized traffic against the reference model
    hold = 0;
    pend = 0;
    pw = 0;
    pd = '0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (pend) begin
        if (pw == 0) begin
          mem_data_ok = 1'b1;
          mem_rdata = pd;
          pend = 0;
        end else begin
          mem_data_ok = 1'b0;
          mem_rdata = $urandom;
          pw--;
        end
      end else begin
        mem_data_ok = 1'b0;
        mem_rdata = $urandom;
      end
      if (!hold) begin
        if ($urandom_range(3) == 0) begin
          idle_ex();
        end else begin
          int sz, lo;
          sz = $urandom_range(2);
          lo = $urandom_range(3);
          if (sz == 1) lo = lo & 2;
          if (sz == 2) lo = 0;
          drive_ex(1, $urandom_range(3) != 0, $urandom_range(31), $urandom,
                   $urandom_range(1), sz, $urandom_range(1), lo);
        end
      end
      #1;
      chk("rnd_fwd_ex_we", fwd_ex_rf_we,
          exif.ex_valid && exif.ex_rf_we && exif.ex_rf_waddr != 0);
      chk("rnd_fwd_ex_re", fwd_ex_mem_re, exif.ex_valid && exif.ex_mem_re);
      if (exif.ex_valid && exif.ex_allowin) begin
        logic [DATA_W-1:0] val;
        int at;
        hold = 0;
        if (exif.ex_mem_re) begin
          pend = 1;
          pw = $urandom_range(3);
          pd = $urandom;
          val = ld_model(pd, int'(exif.ex_ld_size), exif.ex_ld_unsigned, int'(exif.ex_addr_lo));
          at = cyc + 2 + pw;
        end else begin
          val = exif.ex_rf_wdata;
          at = cyc + 2;
        end
        if (exif.ex_rf_we && exif.ex_rf_waddr != 0) push_wr(int'(exif.ex_rf_waddr), val, at);
      end else begin
        hold = exif.ex_valid;
      end
    end
    idle_ex();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pend && pw == 0) begin
        mem_data_ok = 1'b1;
        mem_rdata = pd;
        pend = 0;
      end else begin
        mem_data_ok = 1'b0;
        if (pend) pw--;
      end
    end
    idle_cycles(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
